mem_arbiter_ctrl: RTL and testbench
===================================

# mem_arbiter_ctrl

Parametrised multi-channel memory controller that sits between several requesters (CPU load/store unit, DMA, debug port) and a single-port synchronous RAM. It accepts read and write requests from NUM_CH channels, arbitrates round-robin, and drives the RAM strobes. It waits a configurable read latency and returns a per-channel completion pulse. It supersedes the single-requester, fixed-16-bit controller with fixed read latency.

## Interface
- DATA_W, 16: data word width in bits.
- ADDR_W, 16: address width in bits.
- NUM_CH, 2: number of requester channels, 1..8.
- RD_LAT, 1: RAM read latency in cycles, 1..15. ram_oe is held this long.

- clk  in  1  single clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CH  per-channel request level.
- req_we  in  NUM_CH  per-channel type: 1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_W  packed addresses. Channel i is at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  packed write data.
- ack  out  NUM_CH  one-cycle pulse: request accepted.
- wr_done  out  NUM_CH  one-cycle pulse: write committed.
- rsp_valid  out  NUM_CH  one-cycle pulse: rsp_rdata is valid for this channel.
- rsp_rdata  out  DATA_W  read data. Shared by all channels.
- ram_we, ram_oe  out  1  RAM write strobe and output-enable strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

## Operation
- States:
  - IDLE: accepts requests.
  - WR: performs the write.
  - RD: performs the read.
  - RESP: issues the completion pulse.
- IDLE:
  - If any req bit is high, select the winner by round-robin, starting from the channel after last_grant.
  - Latch the winner's we/addr/wdata and update last_grant.
  - Go to WR if req_we=1, else to RD.
- WR: ram_we=1 for exactly one cycle, then RESP.
- RD: ram_oe=1 for RD_LAT cycles (counter of width clog2(RD_LAT+1)). On the final RD cycle edge, capture ram_rdata into rsp_rdata. Then RESP.
- RESP: pulse wr_done[w] or rsp_valid[w] for one cycle, then IDLE.
- Request semantics:
  - A request is a level, sampled only in IDLE.
  - The requester holds req/we/addr/wdata stable until ack, then drops req.
  - If req is still high when the FSM re-enters IDLE, it is a new request.
- If req is dropped before ack, no access occurs.
- A req in any non-IDLE state is ignored, not queued.
- Outputs are mutually exclusive: ram_we and ram_oe are never high together. At most one bit of ack/wr_done/rsp_valid is high per cycle.
- rsp_rdata holds its last captured value until the next read completes.
- All outputs are registered.

## Timing
- Reset values:
  - state=IDLE; last_grant=NUM_CH-1, so channel 0 wins first.
  - ack, wr_done, rsp_valid, ram_we, ram_oe = 0.
  - ram_addr, ram_wdata, rsp_rdata = 0.
- Request sampled in IDLE at edge T:
  - ack[w] is high in cycle T+1.
  - ram_addr and the strobe are valid from cycle T+1.
- Write:
  - ram_we high in cycle T+1.
  - wr_done[w] high in cycle T+2.
  - IDLE again at T+3. Minimum write issue interval is 3 cycles.
- Read:
  - ram_oe high in cycles T+1 .. T+RD_LAT.
  - rsp_valid[w] and rsp_rdata valid in cycle T+RD_LAT+1.
  - Minimum read interval is RD_LAT+2 cycles.
- Simultaneous requests from all channels are served in rotating order 0,1,..,NUM_CH-1,0,…
- NUM_CH=1 degenerates to a fixed grant to channel 0.
- Reset asserted mid-access:
  - All outputs return to reset values on the next edge.
  - The in-flight access is abandoned with no completion pulse.
  - The pointer is reset.

## Configuration
- MEMCTRL_WSTRB_EN defined:
  - Adds input req_wstrb (NUM_CH*DATA_W/8) and output ram_wstrb (DATA_W/8).
  - ram_wstrb is latched with the request and driven during WR, 0 otherwise.
  - DATA_W must be a multiple of 8.
- Not defined: no strobe ports. All writes are full-word.

## Test plan
- Reset, then ch0 write 0x1234 to 0x0010: ack[0] in cycle 1, ram_we in cycle 1 with addr 0x0010, wr_done[0] in cycle 2.
- RD_LAT=3, ch1 read 0x0010 with RAM returning 0x1234: ram_oe high for 3 cycles, then rsp_valid[1]=1 with rsp_rdata=0x1234 in cycle 4.
- NUM_CH=4, all req held continuously: grants 0,1,2,3,0 in order, never two acks in one cycle.
- req[1] pulsed for one cycle while the FSM is busy on ch0: no ack[1], and no access to ch1's address.
- Reset asserted in the 2nd ram_oe cycle of a read: no rsp_valid, all outputs 0 next cycle, and the next request from ch0 wins.
- MEMCTRL_WSTRB_EN, DATA_W=16, wstrb=2'b10: ram_wstrb=2'b10 during ram_we only.

Source files
------------

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin multi-channel controller for a single-port synchronous RAM.
// Optional byte write strobes are enabled by defining MEMCTRL_WSTRB_EN.
module mem_arbiter_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH-1:0]          req_we,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          ack,
    output logic [NUM_CH-1:0]          wr_done,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       ram_we,
    output logic                       ram_oe,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_wdata,
`ifdef MEMCTRL_WSTRB_EN
    input  logic [NUM_CH*DATA_W/8-1:0] req_wstrb,
    output logic [DATA_W/8-1:0]        ram_wstrb,
`endif
    input  logic [DATA_W-1:0]          ram_rdata
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
`ifdef MEMCTRL_WSTRB_EN
    localparam int unsigned STRB_W = DATA_W / 8;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_RESP} state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    last_grant_q;
    logic [IDX_W-1:0]    ch_q;
    logic [CNT_W-1:0]    rd_cnt_q;
    logic [NUM_CH-1:0]   ack_q, wr_done_q, rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q, ram_wdata_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic                ram_we_q, ram_oe_q;

    logic                grant_vld_d;
    logic [IDX_W-1:0]    grant_idx_d;
    logic [NUM_CH-1:0]   grant_oh_d;
    logic [NUM_CH-1:0]   ch_oh;

    // Round-robin search starting at the channel after the last grant
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand        = '0;
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = IDX_W'((32'(last_grant_q) + k) % NUM_CH);
            if (!grant_vld_d && req[cand]) begin
                grant_vld_d = 1'b1;
                grant_idx_d = cand;
            end
        end
    end

    assign grant_oh_d = NUM_CH'(1) << grant_idx_d;
    assign ch_oh      = NUM_CH'(1) << ch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_CH - 1);
            ch_q         <= '0;
            rd_cnt_q     <= '0;
            ack_q        <= '0;
            wr_done_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            ram_we_q     <= 1'b0;
            ram_oe_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
`ifdef MEMCTRL_WSTRB_EN
            ram_wstrb    <= '0;
`endif
        end else begin
            ack_q       <= '0;
            wr_done_q   <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_d) begin
                        ack_q        <= grant_oh_d;
                        last_grant_q <= grant_idx_d;
                        ch_q         <= grant_idx_d;
                        ram_addr_q   <= req_addr[32'(grant_idx_d)*ADDR_W +: ADDR_W];
                        ram_wdata_q  <= req_wdata[32'(grant_idx_d)*DATA_W +: DATA_W];
                        if (req_we[grant_idx_d]) begin
                            ram_we_q <= 1'b1;
`ifdef MEMCTRL_WSTRB_EN
                            ram_wstrb <= req_wstrb[32'(grant_idx_d)*STRB_W +: STRB_W];
`endif
                            state_q  <= ST_WR;
                        end else begin
                            ram_oe_q <= 1'b1;
                            rd_cnt_q <= CNT_W'(1);
                            state_q  <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    ram_we_q  <= 1'b0;
`ifdef MEMCTRL_WSTRB_EN
                    ram_wstrb <= '0;
`endif
                    wr_done_q <= ch_oh;
                    state_q   <= ST_RESP;
                end
                ST_RD: begin
                    // rd_cnt_q counts the ram_oe cycles already issued
                    if (rd_cnt_q == CNT_W'(RD_LAT)) begin
                        ram_oe_q    <= 1'b0;
                        rsp_rdata_q <= ram_rdata;
                        rsp_valid_q <= ch_oh;
                        state_q     <= ST_RESP;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign wr_done   = wr_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl: 4 channels, read latency 3.
module tb_mem_arbiter_ctrl;

    localparam int NCH = 4;
    localparam int RDL = 3;
    localparam int DW  = 16;
    localparam int AW  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    req_we = '0;
    logic [NCH*AW-1:0] req_addr = '0;
    logic [NCH*DW-1:0] req_wdata = '0;
    logic [NCH-1:0]    ack, wr_done, rsp_valid;
    logic [DW-1:0]     rsp_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0]     ram_addr;
    logic              ram_we, ram_oe;
`ifdef MEMCTRL_WSTRB_EN
    logic [NCH*DW/8-1:0] req_wstrb = {NCH{2'b10}};
    logic [DW/8-1:0]     ram_wstrb;
`endif

    mem_arbiter_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .RD_LAT(RDL)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .wr_done(wr_done), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef MEMCTRL_WSTRB_EN
        .req_wstrb(req_wstrb), .ram_wstrb(ram_wstrb),
`endif
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 16'hA500 + 16'(i);
    always @(posedge clk) if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    assign ram_rdata = mem[ram_addr[7:0]];

    typedef struct {
        int          kind;  // 0 ack, 1 wr_done, 2 rsp_valid
        int          ch;
        logic [15:0] addr;
        logic [15:0] data;
        logic        we;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] hold = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int ch, input logic [15:0] addr,
                        input logic [15:0] data, input logic we);
        exp_t e;
        e.kind = kind; e.ch = ch; e.addr = addr; e.data = data; e.we = we;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses a handshake output
    int cyc = 0;
    int last_ack_cyc = 0;
    int oe_run = 0;
    logic oe_prev = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                chk("we_oe_excl", 32'(ram_we & ram_oe), 0);
                chk("pulse_onehot", 32'($countones({ack, wr_done, rsp_valid}) > 1), 0);
`ifdef MEMCTRL_WSTRB_EN
                chk("ram_wstrb", 32'(ram_wstrb), ram_we ? 32'h2 : 32'h0);
`endif
                if ((ram_we || ram_oe) && ram_addr == 16'h0BAD) begin
                    total++; bad++;
                    $display("FAIL ignored_req_access: got addr %h required no access", ram_addr);
                end
                if (ram_oe) oe_run++;
                if (!ram_oe && oe_prev) chk("oe_len", 32'(oe_run), 32'(RDL));
                if (!ram_oe) oe_run = 0;
                if (ack != 0 || wr_done != 0 || rsp_valid != 0) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_pulse: got ack=%b wr_done=%b rsp_valid=%b required none",
                                 ack, wr_done, rsp_valid);
                    end else begin
                        e = q.pop_front();
                        case (e.kind)
                            0: begin
                                chk("ack_ch", 32'(ack), 32'(4'(1) << e.ch));
                                chk("ack_addr", 32'(ram_addr), 32'(e.addr));
                                chk("ack_we", 32'(ram_we), 32'(e.we));
                                chk("ack_oe", 32'(ram_oe), 32'(!e.we));
                                if (e.we) chk("ack_wdata", 32'(ram_wdata), 32'(e.data));
                                last_ack_cyc = cyc;
                            end
                            1: begin
                                chk("wr_done_ch", 32'(wr_done), 32'(4'(1) << e.ch));
                                chk("wr_done_lat", 32'(cyc - last_ack_cyc), 1);
                                chk("rdata_hold", 32'(rsp_rdata), 32'(e.data));
                            end
                            default: begin
                                chk("rsp_ch", 32'(rsp_valid), 32'(4'(1) << e.ch));
                                chk("rsp_lat", 32'(cyc - last_ack_cyc), 32'(RDL));
                                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                            end
                        endcase
                    end
                end
            end
            oe_prev = reset ? 1'b0 : ram_oe;
            if (reset) oe_run = 0;
        end
    end

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(q.size()), 0);
    endtask

    task automatic set_ch(input int ch, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        req_we[ch] = we;
        req_addr[ch*AW +: AW] = addr;
        req_wdata[ch*DW +: DW] = wd;
    endtask

    // One isolated request; rexp is the expected read data (ignored for writes)
    task automatic single(input int ch, input logic we, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] rexp);
        int n = 0;
        @(negedge clk);
        set_ch(ch, we, addr, wd);
        push(0, ch, addr, wd, we);
        if (we) push(1, ch, addr, hold, 1'b1);
        else begin
            push(2, ch, addr, rexp, 1'b0);
            hold = rexp;
        end
        req[ch] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[ch] && n < 50);
        chk("ack_latency", 32'(n), 1);
        req[ch] = 1'b0;
        drain();
    endtask

    initial begin
        int n;
        int cnt;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_wr_done", 32'(wr_done), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_strobes", 32'({ram_we, ram_oe}), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_wdata", 32'(ram_wdata), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        reset = 1'b0;

        single(0, 1'b1, 16'h0010, 16'h1234, 16'h0);
        single(1, 1'b0, 16'h0010, 16'h0, 16'h1234);
        single(0, 1'b0, 16'h0005, 16'h0, 16'hA505);
        single(2, 1'b1, 16'h0020, 16'hBEEF, 16'h0);
        single(3, 1'b0, 16'h0020, 16'h0, 16'hBEEF);

        // All channels request continuously: rotation 0,1,2,3,0
        @(negedge clk);
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 16'h0030 + 16'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 5; i++) begin
            push(0, i % NCH, 16'h0030 + 16'(i % NCH), 16'h1000 + 16'(i % NCH), 1'b1);
            push(1, i % NCH, 16'h0030 + 16'(i % NCH), hold, 1'b1);
        end
        req = '1;
        n = 0; cnt = 0;
        while (cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
            if (ack != 0) cnt++;
        end
        chk("rr_grants", 32'(cnt), 5);
        req = '0;
        drain();

        // ch1 pulses a request while ch0 is reading: must be ignored
        @(negedge clk);
        set_ch(0, 1'b0, 16'h0031, 16'h0);
        push(0, 0, 16'h0031, 16'h0, 1'b0);
        push(2, 0, 16'h0031, 16'h1001, 1'b0);
        hold = 16'h1001;
        req[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack[0] && n < 50);
        chk("busy_ack0", 32'(ack[0]), 1);
        req[0] = 1'b0;
        set_ch(1, 1'b0, 16'h0BAD, 16'h0);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // Reset during the second ram_oe cycle of a ch0 read
        set_ch(0, 1'b0, 16'h0020, 16'h0);
        push(0, 0, 16'h0020, 16'h0, 1'b0);
        req[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack[0] && n < 50);
        req[0] = 1'b0;
        @(negedge clk);
        chk("oe_2nd_cycle", 32'(ram_oe), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pulses", 32'({ack, wr_done, rsp_valid}), 0);
        chk("mid_rst_strobes", 32'({ram_we, ram_oe}), 0);
        chk("mid_rst_addr", 32'(ram_addr), 0);
        chk("mid_rst_rdata", 32'(rsp_rdata), 0);
        chk("mid_rst_sb", 32'(q.size()), 0);
        reset = 1'b0;
        hold = '0;

        // Pointer reset: ch0 beats ch3 on the first request after reset
        set_ch(0, 1'b1, 16'h0040, 16'h5555);
        set_ch(3, 1'b1, 16'h0041, 16'h6666);
        push(0, 0, 16'h0040, 16'h5555, 1'b1);
        push(1, 0, 16'h0040, hold, 1'b1);
        push(0, 3, 16'h0041, 16'h6666, 1'b1);
        push(1, 3, 16'h0041, hold, 1'b1);
        req[0] = 1'b1;
        req[3] = 1'b1;
        n = 0;
        while ((req[0] || req[3]) && n < 50) begin
            @(negedge clk);
            n++;
            if (ack[0]) req[0] = 1'b0;
            if (ack[3]) req[3] = 1'b0;
        end
        chk("post_rst_acks_done", 32'({req[0], req[3]}), 0);
        req = '0;
        drain();
        single(3, 1'b0, 16'h0040, 16'h0, 16'h5555);

        repeat (3) @(negedge clk);
        chk("sb_empty_end", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
